// File: rtl/fb_rd_sched_if.sv
// Reader-side bus between the frame read scheduler and the AXI4-to-stream line reader.
interface fb_rd_sched_if #(
    parameter int unsigned ADDR_WIDTH         = 32,
    parameter int unsigned MAX_PKT_SIZE_WIDTH = 13
);
    logic                          rd_stb_o;
    logic [ADDR_WIDTH-1:0]         addr_o;
    logic [MAX_PKT_SIZE_WIDTH:0]   pkt_size_o;
    logic                          pkt_done_i;

    modport master (
        output rd_stb_o,
        output addr_o,
        output pkt_size_o,
        input  pkt_done_i
    );

    modport slave (
        input  rd_stb_o,
        input  addr_o,
        input  pkt_size_o,
        output pkt_done_i
    );
endinterface

// File: rtl/fb_rd_sched.sv
// Frame-level read scheduler: picks the newest completed write buffer on each frame request
// and walks the line reader through the frame one packet at a time.
module fb_rd_sched #(
    parameter int unsigned           ADDR_WIDTH         = 32,
    parameter int unsigned           BUF_NUM            = 3,
    parameter int unsigned           BUF_IDX_WIDTH      = 2,
    parameter logic [ADDR_WIDTH-1:0] FB_BASE_ADDR       = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE_B     = 32'h0080_0000,
    parameter int unsigned           LINE_STRIDE_B      = 8192,
    parameter int unsigned           MAX_PKT_SIZE_WIDTH = 13,
    parameter int unsigned           LINES_WIDTH        = 12
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         frame_start_i,
    input  logic [MAX_PKT_SIZE_WIDTH:0]  line_size_i,
    input  logic [LINES_WIDTH-1:0]       lines_i,
    input  logic                         wr_done_i,
    input  logic [BUF_IDX_WIDTH-1:0]     wr_buf_i,
    fb_rd_sched_if.master                rd_if,
    output logic [BUF_IDX_WIDTH-1:0]     rd_buf_o,
    output logic                         busy_o,
    output logic                         frame_done_o,
    output logic                         frame_skip_o,
    output logic                         frame_drop_o
);

    typedef enum logic [1:0] {StIdle, StSelBuf, StIssue, StWaitPkt} state_e;

    state_e                      state_q, state_d;
    logic [BUF_IDX_WIDTH-1:0]    latest_idx_q;
    logic                        latest_vld_q;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [MAX_PKT_SIZE_WIDTH:0] size_q, size_d;
    logic [BUF_IDX_WIDTH-1:0]    buf_q, buf_d;
    logic [LINES_WIDTH-1:0]      lines_q, lines_d;
    logic [LINES_WIDTH-1:0]      cnt_q, cnt_d;
    logic                        stb_q, done_q, done_d, skip_q, skip_d, drop_q;

    // A writer completing in the selection cycle wins over the stored index.
    logic [BUF_IDX_WIDTH-1:0] sel_idx;
    logic                     sel_vld;
    logic [ADDR_WIDTH-1:0]    frame_base;

    assign sel_idx    = wr_done_i ? wr_buf_i : latest_idx_q;
    assign sel_vld    = latest_vld_q | wr_done_i;
    assign frame_base = FB_BASE_ADDR + ADDR_WIDTH'(sel_idx) * FRAME_STRIDE_B;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        buf_d   = buf_q;
        lines_d = lines_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        skip_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_start_i) state_d = StSelBuf;
            end
            StSelBuf: begin
                if (!sel_vld || line_size_i == '0 || lines_i == '0) begin
                    skip_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    buf_d   = sel_idx;
                    size_d  = line_size_i;
                    lines_d = lines_i;
                    addr_d  = frame_base;
                    cnt_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWaitPkt;
            StWaitPkt: begin
                if (rd_if.pkt_done_i) begin
                    if (cnt_q == lines_q - LINES_WIDTH'(1)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d   = cnt_q + LINES_WIDTH'(1);
                        addr_d  = addr_q + ADDR_WIDTH'(LINE_STRIDE_B);
                        state_d = StIssue;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            latest_idx_q <= '0;
            latest_vld_q <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            buf_q        <= '0;
            lines_q      <= '0;
            cnt_q        <= '0;
            stb_q        <= 1'b0;
            done_q       <= 1'b0;
            skip_q       <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_done_i) begin
                latest_idx_q <= wr_buf_i;
                latest_vld_q <= 1'b1;
            end
            addr_q  <= addr_d;
            size_q  <= size_d;
            buf_q   <= buf_d;
            lines_q <= lines_d;
            cnt_q   <= cnt_d;
            stb_q   <= (state_d == StIssue);
            done_q  <= done_d;
            skip_q  <= skip_d;
            drop_q  <= frame_start_i && (state_q != StIdle);
        end
    end

    assign rd_if.rd_stb_o   = stb_q;
    assign rd_if.addr_o     = addr_q;
    assign rd_if.pkt_size_o = size_q;
    assign rd_buf_o         = buf_q;
    assign busy_o           = (state_q != StIdle);
    assign frame_done_o     = done_q;
    assign frame_skip_o     = skip_q;
    assign frame_drop_o     = drop_q;

    wr_buf_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
        wr_done_i |-> (int'(wr_buf_i) < int'(BUF_NUM)));

endmodule

// File: tb/tb_fb_rd_sched.sv
// Self-checking bench for fb_rd_sched: directed scenarios plus randomized frames against a
// frame-level model of buffer selection and line addressing.
module tb_fb_rd_sched;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        frame_start_i = 1'b0;
    logic [13:0] line_size_i = 14'd100;
    logic [11:0] lines_i = 12'd3;
    logic        wr_done_i = 1'b0;
    logic [1:0]  wr_buf_i = 2'd0;
    logic [1:0]  rd_buf_o;
    logic        busy_o, frame_done_o, frame_skip_o, frame_drop_o;

    int checks = 0;
    int errors = 0;

    // Frame-level model state
    int          m_idx = 0;
    bit          m_vld = 1'b0;
    logic [31:0] last_addr = '0;
    int          last_size = 0;
    int          last_buf = 0;

    typedef struct {
        bit wr_pre;
        int pre_buf;
        bit byp;
        int byp_buf;
        int lines;
        int size;
        int delay;
        bit ovl;
    } frame_t;

    fb_rd_sched_if rd_bus ();

    fb_rd_sched dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .frame_start_i (frame_start_i),
        .line_size_i   (line_size_i),
        .lines_i       (lines_i),
        .wr_done_i     (wr_done_i),
        .wr_buf_i      (wr_buf_i),
        .rd_if         (rd_bus),
        .rd_buf_o      (rd_buf_o),
        .busy_o        (busy_o),
        .frame_done_o  (frame_done_o),
        .frame_skip_o  (frame_skip_o),
        .frame_drop_o  (frame_drop_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] exp_addr(int idx, int ln);
        return 32'h0000_0000 + 32'(idx) * 32'h0080_0000 + 32'(ln) * 32'd8192;
    endfunction

    task automatic test_reset();
        rd_bus.pkt_done_i = 1'b0;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        checks++;
        if ({rd_bus.rd_stb_o, busy_o, frame_done_o, frame_skip_o, frame_drop_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {rd_bus.rd_stb_o, busy_o, frame_done_o, frame_skip_o, frame_drop_o});
        end
        checks++;
        if (rd_bus.addr_o !== 32'h0 || rd_bus.pkt_size_o !== 14'h0 || rd_buf_o !== 2'h0) begin
            errors++;
            $display("FAIL reset_regs: got addr=%h size=%0d buf=%0d expected 0/0/0",
                     rd_bus.addr_o, rd_bus.pkt_size_o, rd_buf_o);
        end
        m_vld = 1'b0;
    endtask

    task automatic test_no_buffer();
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || rd_bus.rd_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL nobuf_sel: got busy=%b stb=%b expected busy=1 stb=0",
                     busy_o, rd_bus.rd_stb_o);
        end
        tick();
        checks++;
        if (frame_skip_o !== 1'b1 || rd_bus.rd_stb_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL nobuf_skip: got skip=%b stb=%b busy=%b expected 1/0/0",
                     frame_skip_o, rd_bus.rd_stb_o, busy_o);
        end
        tick();
        checks++;
        if (frame_skip_o !== 1'b0 || rd_bus.rd_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL nobuf_pulse: got skip=%b stb=%b expected 0/0",
                     frame_skip_o, rd_bus.rd_stb_o);
        end
    endtask

    // Fixed entries: basic, repeat, bypass, overlap; then randomized frames.
    task automatic test_frames(input int n_rand);
        frame_t tbl[$];
        frame_t f;
        int     exp_buf;
        tbl.push_back('{1'b1, 1, 1'b0, 0, 3, 100, 10, 1'b0});
        tbl.push_back('{1'b0, 0, 1'b0, 0, 3, 100, 3, 1'b0});
        tbl.push_back('{1'b0, 0, 1'b1, 2, 2, 64, 2, 1'b0});
        tbl.push_back('{1'b0, 0, 1'b0, 0, 3, 200, 4, 1'b1});
        for (int i = 0; i < n_rand; i++) begin
            f.wr_pre  = ($urandom_range(0, 1) == 1);
            f.pre_buf = int'($urandom_range(0, 2));
            f.byp     = ($urandom_range(0, 3) == 0);
            f.byp_buf = int'($urandom_range(0, 2));
            f.lines   = int'($urandom_range(1, 5));
            f.size    = int'($urandom_range(1, 8191));
            f.delay   = int'($urandom_range(1, 6));
            f.ovl     = (f.delay >= 2) && ($urandom_range(0, 2) == 0);
            tbl.push_back(f);
        end

        foreach (tbl[i]) begin
            f = tbl[i];
            if (f.wr_pre) begin
                wr_done_i = 1'b1;
                wr_buf_i  = 2'(f.pre_buf);
                tick();
                wr_done_i = 1'b0;
                m_idx = f.pre_buf;
                m_vld = 1'b1;
            end
            lines_i       = 12'(f.lines);
            line_size_i   = 14'(f.size);
            frame_start_i = 1'b1;
            tick();
            frame_start_i = 1'b0;
            if (f.byp) begin
                wr_done_i = 1'b1;
                wr_buf_i  = 2'(f.byp_buf);
                m_idx = f.byp_buf;
                m_vld = 1'b1;
            end
            checks++;
            if (busy_o !== 1'b1 || rd_bus.rd_stb_o !== 1'b0) begin
                errors++;
                $display("FAIL frame%0d_sel: got busy=%b stb=%b expected 1/0",
                         i, busy_o, rd_bus.rd_stb_o);
            end
            tick();
            wr_done_i   = 1'b0;
            // Config changes mid-frame must be ignored.
            lines_i     = 12'($urandom);
            line_size_i = 14'($urandom);
            exp_buf     = m_idx;

            for (int ln = 0; ln < f.lines; ln++) begin
                checks++;
                if (rd_bus.rd_stb_o !== 1'b1 || rd_bus.addr_o !== exp_addr(exp_buf, ln) ||
                    rd_bus.pkt_size_o !== 14'(f.size) || rd_buf_o !== 2'(exp_buf) ||
                    busy_o !== 1'b1) begin
                    errors++;
                    $display("FAIL frame%0d_line%0d: got stb=%b addr=%h size=%0d buf=%0d busy=%b expected 1 %h %0d %0d 1",
                             i, ln, rd_bus.rd_stb_o, rd_bus.addr_o, rd_bus.pkt_size_o,
                             rd_buf_o, busy_o, exp_addr(exp_buf, ln), f.size, exp_buf);
                end
                tick();
                for (int k = 1; k <= f.delay; k++) begin
                    checks++;
                    if (rd_bus.rd_stb_o !== 1'b0 || busy_o !== 1'b1 || frame_done_o !== 1'b0) begin
                        errors++;
                        $display("FAIL frame%0d_wait%0d: got stb=%b busy=%b done=%b expected 0/1/0",
                                 i, ln, rd_bus.rd_stb_o, busy_o, frame_done_o);
                    end
                    if (f.ovl && ln == 0 && k == 2) begin
                        checks++;
                        if (frame_drop_o !== 1'b1) begin
                            errors++;
                            $display("FAIL frame%0d_drop: got %b expected 1", i, frame_drop_o);
                        end
                    end
                    if (f.ovl && ln == 0 && k == 1) frame_start_i = 1'b1;
                    if (k == f.delay) rd_bus.pkt_done_i = 1'b1;
                    tick();
                    frame_start_i     = 1'b0;
                    rd_bus.pkt_done_i = 1'b0;
                end
            end
            checks++;
            if (frame_done_o !== 1'b1 || busy_o !== 1'b0 || rd_bus.rd_stb_o !== 1'b0) begin
                errors++;
                $display("FAIL frame%0d_done: got done=%b busy=%b stb=%b expected 1/0/0",
                         i, frame_done_o, busy_o, rd_bus.rd_stb_o);
            end
            tick();
            checks++;
            if (frame_done_o !== 1'b0 || frame_drop_o !== 1'b0) begin
                errors++;
                $display("FAIL frame%0d_pulse: got done=%b drop=%b expected 0/0",
                         i, frame_done_o, frame_drop_o);
            end
            last_addr = exp_addr(exp_buf, f.lines - 1);
            last_size = f.size;
            last_buf  = exp_buf;
        end
    endtask

    task automatic test_zero_config();
        int lines_tbl[2] = '{0, 5};
        int size_tbl[2]  = '{100, 0};
        for (int i = 0; i < 2; i++) begin
            lines_i       = 12'(lines_tbl[i]);
            line_size_i   = 14'(size_tbl[i]);
            frame_start_i = 1'b1;
            tick();
            frame_start_i = 1'b0;
            tick();
            checks++;
            if (frame_skip_o !== 1'b1 || rd_bus.rd_stb_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL zero%0d_skip: got skip=%b stb=%b busy=%b expected 1/0/0",
                         i, frame_skip_o, rd_bus.rd_stb_o, busy_o);
            end
            checks++;
            if (rd_bus.addr_o !== last_addr || rd_bus.pkt_size_o !== 14'(last_size) ||
                rd_buf_o !== 2'(last_buf)) begin
                errors++;
                $display("FAIL zero%0d_hold: got addr=%h size=%0d buf=%0d expected %h %0d %0d",
                         i, rd_bus.addr_o, rd_bus.pkt_size_o, rd_buf_o, last_addr, last_size,
                         last_buf);
            end
            tick();
        end
    endtask

    task automatic test_stray_pkt();
        rd_bus.pkt_done_i = 1'b1;
        tick();
        rd_bus.pkt_done_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy_o !== 1'b0 || rd_bus.rd_stb_o !== 1'b0 || frame_done_o !== 1'b0) begin
                errors++;
                $display("FAIL stray%0d: got busy=%b stb=%b done=%b expected 0/0/0",
                         i, busy_o, rd_bus.rd_stb_o, frame_done_o);
            end
            tick();
        end
    endtask

    task automatic test_reset_midframe();
        wr_done_i = 1'b1;
        wr_buf_i  = 2'd0;
        tick();
        wr_done_i     = 1'b0;
        lines_i       = 12'd3;
        line_size_i   = 14'd50;
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        tick();
        tick();
        rd_bus.pkt_done_i = 1'b1;
        tick();
        rd_bus.pkt_done_i = 1'b0;
        checks++;
        if (rd_bus.rd_stb_o !== 1'b1 || rd_bus.addr_o !== exp_addr(0, 1)) begin
            errors++;
            $display("FAIL rstmid_line1: got stb=%b addr=%h expected 1 %h",
                     rd_bus.rd_stb_o, rd_bus.addr_o, exp_addr(0, 1));
        end
        tick();
        rst_i             = 1'b1;
        rd_bus.pkt_done_i = 1'b1;
        tick();
        rst_i             = 1'b0;
        rd_bus.pkt_done_i = 1'b0;
        m_vld = 1'b0;
        checks++;
        if ({rd_bus.rd_stb_o, busy_o, frame_done_o, frame_skip_o, frame_drop_o} !== 5'b0 ||
            rd_bus.addr_o !== 32'h0 || rd_bus.pkt_size_o !== 14'h0 || rd_buf_o !== 2'h0) begin
            errors++;
            $display("FAIL rstmid_clear: got flags=%b addr=%h size=%0d buf=%0d expected all 0",
                     {rd_bus.rd_stb_o, busy_o, frame_done_o, frame_skip_o, frame_drop_o},
                     rd_bus.addr_o, rd_bus.pkt_size_o, rd_buf_o);
        end
        tick();
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        tick();
        checks++;
        if (frame_skip_o !== 1'b1 || rd_bus.rd_stb_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_skip: got skip=%b stb=%b busy=%b expected 1/0/0",
                     frame_skip_o, rd_bus.rd_stb_o, busy_o);
        end
        tick();
    endtask

    initial begin
        rd_bus.pkt_done_i = 1'b0;
        test_reset();
        test_no_buffer();
        test_frames(16);
        test_zero_config();
        test_stray_pkt();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
